// File: rtl/pipo_load_arbiter.sv
// ---------------------------------------------------------------------------
// pipo_load_arbiter
//
// Shares a single PIPO holding register between NREQ requesters. A
// round-robin search picks one pending requester, drives the register's
// load strobe and parallel input (PI) for exactly one cycle, then keeps the
// bus quiet for HOLD_CYCLES cycles so consumers can read the register
// output before anything else is loaded. The index of the requester whose
// data currently sits in the register is reported on owner.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req          level request, bit i belongs to requester i
//   data         requester i payload at data[i*WIDTH +: WIDTH]
//   gnt          one-hot grant, high only during the GRANT cycle
//   load         load strobe to the PIPO register (equals |gnt)
//   PI           parallel data to the PIPO register
//   owner        index of the requester that was loaded last
//   owner_valid  high once any load has happened since reset
//   busy         high whenever the arbiter is not idle
//
// Parameters
//   NREQ         number of requesters (2..8)
//   WIDTH        payload / register width
//   HOLD_CYCLES  quiet cycles after each load before re-arbitration (>=1)
// ---------------------------------------------------------------------------
module pipo_load_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic                    load,
    output logic [WIDTH-1:0]        PI,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    owner_valid,
    output logic                    busy
);

    localparam int IW = $clog2(NREQ);
    // Sized so that HOLD_CYCLES-1 always fits, including HOLD_CYCLES == 1.
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    // After reset the pointer sits on the last requester so that the first
    // search starts at requester 0.
    localparam logic [IW-1:0] PTR_RESET = IW'(NREQ - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   last_winner;
    logic [CW-1:0]   hold_cnt;

    logic            found;
    logic [IW-1:0]   win;
    logic [NREQ-1:0] win_onehot;
    logic [WIDTH-1:0] win_data;

    // Round-robin search: candidates are visited starting one past the
    // previous winner and wrapping around, so the previous winner itself is
    // examined last and therefore has the lowest priority. The modulo keeps
    // this correct for requester counts that are not a power of two.
    always_comb begin
        found = 1'b0;
        win   = last_winner;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last_winner) + k) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(last_winner) + k) % NREQ);
            end
        end
    end

    // Grant vector and payload of the selected requester.
    always_comb begin
        win_onehot      = '0;
        win_onehot[win] = 1'b1;
        win_data        = data[int'(win)*WIDTH +: WIDTH];
    end

    // Control FSM with every output registered. The data seen at the
    // arbitration edge is captured into PI and then held untouched through
    // GRANT, HOLD and any following IDLE cycles, so later changes on data
    // never reach the register. An async reset abandons whatever sequence
    // was in progress and puts the pointer back to its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_winner <= PTR_RESET;
            hold_cnt    <= '0;
            gnt         <= '0;
            load        <= 1'b0;
            PI          <= '0;
            owner       <= '0;
            owner_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        gnt         <= win_onehot;
                        load        <= 1'b1;
                        PI          <= win_data;
                        owner       <= win;
                        owner_valid <= 1'b1;
                        last_winner <= win;
                        busy        <= 1'b1;
                    end
                end

                GRANT: begin
                    gnt      <= '0;
                    load     <= 1'b0;
                    hold_cnt <= HOLD_LOAD;
                    state    <= HOLD;
                end

                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    load  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the grant interface.
    a_load_matches_gnt: assert property (@(posedge clk) disable iff (!rst)
        load == (|gnt));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(gnt));

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipo_load_arbiter
//
// Self-checking bench for pipo_load_arbiter. A behavioural model tracks the
// round-robin pointer as a plain integer and the quiet period as a simple
// cycle countdown; directed scenarios and a randomized run are compared
// against it and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_pipo_load_arbiter;

    localparam int NREQ        = 4;
    localparam int WIDTH       = 4;
    localparam int HOLD_CYCLES = 2;
    localparam int IW          = $clog2(NREQ);
    localparam int DW          = NREQ * WIDTH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [DW-1:0]   data = '0;
    logic [NREQ-1:0] gnt;
    logic            load;
    logic [WIDTH-1:0] PI;
    logic [IW-1:0]   owner;
    logic            owner_valid;
    logic            busy;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int               m_last;
    int               m_cool;
    logic [NREQ-1:0]  m_gnt;
    logic             m_load;
    logic [WIDTH-1:0] m_pi;
    int               m_owner;
    logic             m_ov;
    logic             m_busy;

    pipo_load_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data(data),
        .gnt(gnt),
        .load(load),
        .PI(PI),
        .owner(owner),
        .owner_valid(owner_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void model_reset();
        m_last  = NREQ - 1;
        m_cool  = 0;
        m_gnt   = '0;
        m_load  = 1'b0;
        m_pi    = '0;
        m_owner = 0;
        m_ov    = 1'b0;
        m_busy  = 1'b0;
    endfunction

    // One clock edge of the model: if the quiet period is over and anyone is
    // requesting, the first requester after the previous winner (wrapping)
    // is granted and the next HOLD_CYCLES+1 edges are quiet.
    function automatic void model_step();
        int w;
        int idx;
        w = -1;
        if (m_cool == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (w < 0 && req[idx]) w = idx;
            end
        end
        if (w >= 0) begin
            m_last   = w;
            m_cool   = HOLD_CYCLES + 1;
            m_gnt    = '0;
            m_gnt[w] = 1'b1;
            m_load   = 1'b1;
            m_pi     = data[w*WIDTH +: WIDTH];
            m_owner  = w;
            m_ov     = 1'b1;
            m_busy   = 1'b1;
        end else begin
            m_gnt  = '0;
            m_load = 1'b0;
            if (m_cool > 0) m_cool--;
            m_busy = (m_cool > 0);
        end
    endfunction

    // Advance one clock and leave the bench 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        req = '0;
        data = '0;
        #1 rst = 1'b0;
        model_reset();
        #11;
        total++;
        if ({gnt, load, PI, owner, owner_valid, busy} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_values: got gnt=%b load=%b PI=%b owner=%0d ov=%b busy=%b, expected all zero",
                     gnt, load, PI, owner, owner_valid, busy);
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (load !== 1'b0 || gnt !== '0 || busy !== 1'b0 || owner_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_after_reset: cycle %0d got load=%b gnt=%b busy=%b ov=%b, expected 0",
                         c, load, gnt, busy, owner_valid);
            end
        end
    endtask

    task automatic test_single();
        $display("[TB] test_single");
        data = DW'($urandom);
        data[1*WIDTH +: WIDTH] = 4'b1011;
        req = 4'b0010;
        tick();
        req = '0;
        total++;
        if (gnt !== 4'b0010 || load !== 1'b1 || PI !== 4'b1011 || owner !== IW'(1) ||
            owner_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_grant: got gnt=%b load=%b PI=%b owner=%0d ov=%b busy=%b, expected 0010 1 1011 1 1 1",
                     gnt, load, PI, owner, owner_valid, busy);
        end
        tick();
        total++;
        if (load !== 1'b0 || gnt !== '0 || PI !== 4'b1011 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_after_grant: got load=%b gnt=%b PI=%b busy=%b, expected 0 0000 1011 1",
                     load, gnt, PI, busy);
        end
        tick();
        total++;
        if (busy !== 1'b1 || load !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_hold: got busy=%b load=%b, expected 1 0", busy, load);
        end
        tick();
        total++;
        if (busy !== 1'b0 || PI !== 4'b1011 || owner !== IW'(1)) begin
            bad++;
            $display("[TB] FAIL single_idle: got busy=%b PI=%b owner=%0d, expected 0 1011 1", busy, PI, owner);
        end
    endtask

    task automatic test_rotation();
        int n_loads;
        int last_load_cycle;
        int exp_owner [5] = '{0, 1, 2, 3, 0};
        logic [WIDTH-1:0] exp_pi [5] = '{4'b1001, 4'b0011, 4'b1010, 4'b1111, 4'b1001};
        $display("[TB] test_rotation");
        apply_reset();
        data = {4'b1111, 4'b1010, 4'b0011, 4'b1001};
        req = 4'b1111;
        n_loads = 0;
        last_load_cycle = -1;
        for (int c = 0; c < 40 && n_loads < 5; c++) begin
            tick();
            total++;
            if (load !== m_load || gnt !== m_gnt || PI !== m_pi || busy !== m_busy) begin
                bad++;
                $display("[TB] FAIL rot_model: cycle %0d got load=%b gnt=%b PI=%b busy=%b, expected %b %b %b %b",
                         c, load, gnt, PI, busy, m_load, m_gnt, m_pi, m_busy);
            end
            if (load === 1'b1) begin
                total++;
                if (owner !== IW'(exp_owner[n_loads]) || PI !== exp_pi[n_loads]) begin
                    bad++;
                    $display("[TB] FAIL rot_sequence: grant %0d got owner=%0d PI=%b, expected %0d %b",
                             n_loads, owner, PI, exp_owner[n_loads], exp_pi[n_loads]);
                end
                if (last_load_cycle >= 0) begin
                    total++;
                    if (c - last_load_cycle !== 2 + HOLD_CYCLES) begin
                        bad++;
                        $display("[TB] FAIL rot_spacing: got %0d cycles, expected %0d",
                                 c - last_load_cycle, 2 + HOLD_CYCLES);
                    end
                end
                last_load_cycle = c;
                n_loads++;
            end
        end
        total++;
        if (n_loads !== 5) begin
            bad++;
            $display("[TB] FAIL rot_timeout: got %0d loads, expected 5", n_loads);
        end
    endtask

    task automatic test_pointer_wrap();
        int n;
        bit seen2;
        int exp_owner [2] = '{0, 2};
        $display("[TB] test_pointer_wrap");
        apply_reset();
        data = DW'($urandom);
        req = 4'b1111;
        seen2 = 0;
        for (int c = 0; c < 30 && !seen2; c++) begin
            tick();
            if (load === 1'b1 && owner === IW'(2)) seen2 = 1;
        end
        total++;
        if (!seen2) begin
            bad++;
            $display("[TB] FAIL wrap_reach_owner2: got no grant to 2, expected one within 30 cycles");
        end
        req = 4'b0101;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (load === 1'b1) begin
                total++;
                if (owner !== IW'(exp_owner[n]) || owner !== IW'(m_owner)) begin
                    bad++;
                    $display("[TB] FAIL wrap_order: grant %0d got owner=%0d, expected %0d",
                             n, owner, exp_owner[n]);
                end
                n++;
            end
        end
        total++;
        if (n !== 2) begin
            bad++;
            $display("[TB] FAIL wrap_timeout: got %0d grants, expected 2", n);
        end
    endtask

    task automatic test_data_hold();
        $display("[TB] test_data_hold");
        apply_reset();
        data = '0;
        data[1*WIDTH +: WIDTH] = 4'b1011;
        req = 4'b0010;
        tick();
        data[1*WIDTH +: WIDTH] = 4'b0000;
        req = '0;
        total++;
        if (PI !== 4'b1011 || load !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_grant: got PI=%b load=%b, expected 1011 1", PI, load);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (PI !== 4'b1011 || load !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_pi_stable: cycle %0d got PI=%b load=%b, expected 1011 0", c, PI, load);
            end
        end
        req = 4'b0010;
        tick();
        total++;
        if (load !== 1'b1 || PI !== 4'b0000 || owner !== IW'(1)) begin
            bad++;
            $display("[TB] FAIL hold_next_grant: got load=%b PI=%b owner=%0d, expected 1 0000 1", load, PI, owner);
        end
    endtask

    task automatic test_reset_mid();
        bit seen2;
        bit granted;
        $display("[TB] test_reset_mid");
        apply_reset();
        data = DW'($urandom);
        req = 4'b1111;
        seen2 = 0;
        for (int c = 0; c < 30 && !seen2; c++) begin
            tick();
            if (load === 1'b1 && owner === IW'(2)) seen2 = 1;
        end
        total++;
        if (!seen2) begin
            bad++;
            $display("[TB] FAIL mid_reach_owner2: got no grant to 2, expected one within 30 cycles");
        end
        tick();
        total++;
        if (busy !== 1'b1 || load !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_in_hold: got busy=%b load=%b, expected 1 0", busy, load);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        total++;
        if ({gnt, load, PI, owner, owner_valid, busy} !== '0) begin
            bad++;
            $display("[TB] FAIL mid_async_clear: got gnt=%b load=%b PI=%b owner=%0d ov=%b busy=%b, expected all zero",
                     gnt, load, PI, owner, owner_valid, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        granted = 0;
        for (int c = 0; c < 10 && !granted; c++) begin
            tick();
            total++;
            if (load !== m_load || gnt !== m_gnt) begin
                bad++;
                $display("[TB] FAIL mid_release_model: cycle %0d got load=%b gnt=%b, expected %b %b",
                         c, load, gnt, m_load, m_gnt);
            end
            if (load === 1'b1) begin
                granted = 1;
                total++;
                if (owner !== IW'(0) || gnt !== 4'b0001) begin
                    bad++;
                    $display("[TB] FAIL mid_first_grant: got owner=%0d gnt=%b, expected 0 0001", owner, gnt);
                end
            end
        end
        total++;
        if (!granted) begin
            bad++;
            $display("[TB] FAIL mid_timeout: got no grant, expected one within 10 cycles");
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            req  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            data = DW'($urandom);
            tick();
            total++;
            if (gnt !== m_gnt || load !== m_load || PI !== m_pi || owner !== IW'(m_owner) ||
                owner_valid !== m_ov || busy !== m_busy) begin
                bad++;
                $display("[TB] FAIL random_model: cycle %0d got gnt=%b load=%b PI=%b owner=%0d ov=%b busy=%b, expected %b %b %b %0d %b %b",
                         c, gnt, load, PI, owner, owner_valid, busy,
                         m_gnt, m_load, m_pi, m_owner, m_ov, m_busy);
            end
            total++;
            if (!$onehot0(gnt) || load !== (|gnt)) begin
                bad++;
                $display("[TB] FAIL random_invariant: cycle %0d got gnt=%b load=%b, expected onehot0 and load==|gnt",
                         c, gnt, load);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_pointer_wrap();
        test_data_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
